gf_mul_mem_dual: RTL and testbench

GF_MUL_MEM_DUAL -- requirements
Module: gf_mul_mem_dual

---
 rtl/gf_mul_mem_dual_pkg.sv | 27 ++
 rtl/gf_mul_mem_dual_if.sv | 32 +++
 rtl/gf_mul_mem_dual_gf_mul.sv | 33 +++
 rtl/gf_mul_mem_dual_mem_dual.sv | 28 ++
 rtl/gf_mul_mem_dual.sv | 94 +++++++++
 tb/tb_gf_mul_mem_dual.sv | 181 ++++++++++++++++++
 6 files changed

// File: rtl/gf_mul_mem_dual_pkg.sv
// Shared constants and helpers for the GF(2^8) multiply-accumulate block.
// Lane 0 sits in the most significant byte of a vector word.
package gf_mul_mem_dual_pkg;

    localparam int          GF_W     = 8;
    localparam logic [7:0]  GF_POLY  = 8'h1B;
    localparam int          N_GF_DEF = 8;

    function automatic int lane_lsb(input int width, input int k);
        return width - GF_W - GF_W * k;
    endfunction

    // Carry-less product to 15 bits, then fold the high bits back down.
    function automatic logic [7:0] gf_mult(input logic [7:0] a,
                                           input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ (15'(a) << i);
        end
        for (int i = 14; i >= 8; i--) begin
            if (p[i]) p = p ^ (15'({1'b1, GF_POLY}) << (i - 8));
        end
        return p[7:0];
    endfunction

endpackage

// File: rtl/gf_mul_mem_dual_if.sv
// Operation / readout bundle of the GF multiply-accumulate block.
// The master drives requests, the slave returns products and read data.
interface gf_mul_mem_dual_if
    import gf_mul_mem_dual_pkg::*;
#(
    parameter int N_GF  = N_GF_DEF,
    parameter int DEPTH = 16
);
    localparam int WIDTH = N_GF * GF_W;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             i_start;
    logic [WIDTH-1:0] i_a;
    logic [7:0]       i_b;
    logic [AW-1:0]    i_addr;
    logic             i_rd_en;
    logic [AW-1:0]    i_rd_addr;
    logic [WIDTH-1:0] o_prod;
    logic             o_valid;
    logic [WIDTH-1:0] o_rd_data;

    modport master (
        output i_start, i_a, i_b, i_addr, i_rd_en, i_rd_addr,
        input  o_prod, o_valid, o_rd_data
    );

    modport slave (
        input  i_start, i_a, i_b, i_addr, i_rd_en, i_rd_addr,
        output o_prod, o_valid, o_rd_data
    );

endinterface

// File: rtl/gf_mul_mem_dual_gf_mul.sv
// One GF(2^8) multiplier lane with a single register stage.
// done is a one-cycle echo of i_start.
module gf_mul
    import gf_mul_mem_dual_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [7:0] in_1,
    input  logic [7:0] in_2,
    output logic [7:0] out,
    output logic       done
);

    logic [7:0] out_q, out_d;
    logic       done_q;

    assign out_d = i_start ? gf_mult(in_1, in_2) : out_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_q  <= '0;
            done_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            done_q <= i_start;
        end
    end

    assign out  = out_q;
    assign done = done_q;

endmodule

// File: rtl/gf_mul_mem_dual_mem_dual.sv
// Dual-port synchronous RAM, read-first on both ports.
// Contents start at zero and are never touched by reset.
module mem_dual #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             i_clk,
    input  logic [WIDTH-1:0] data0_i,
    input  logic [AW-1:0]    addr0_i,
    input  logic             wren0_i,
    output logic [WIDTH-1:0] q0_o,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [AW-1:0]    addr1_i,
    input  logic             wren1_i,
    output logic [WIDTH-1:0] q1_o
);

    logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};

    always_ff @(posedge i_clk) begin
        if (wren0_i) mem[addr0_i] <= data0_i;
        if (wren1_i) mem[addr1_i] <= data1_i;
        q0_o <= mem[addr0_i];
        q1_o <= mem[addr1_i];
    end

endmodule

// File: rtl/gf_mul_mem_dual.sv
// Vector-by-scalar GF(2^8) multiply, XOR-accumulated into a RAM word.
// Write happens the cycle after accept; back-to-back hits are forwarded.
module gf_mul_mem_dual
    import gf_mul_mem_dual_pkg::*;
#(
    parameter int N_GF  = N_GF_DEF,
    parameter int DEPTH = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,
    gf_mul_mem_dual_if.slave bus
);

    localparam int WIDTH = N_GF * GF_W;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             accept;
    logic [N_GF-1:0]  done;
    logic [WIDTH-1:0] prod;
    logic             valid;
    logic             wren;
    logic [WIDTH-1:0] q0, q1;
    logic [WIDTH-1:0] old_val;
    logic [WIDTH-1:0] wdata;
    logic [AW-1:0]    rd_addr;

    logic [AW-1:0]    addr_q, addr_d;
    logic             fwd_hit_q, fwd_hit_d;
    logic [WIDTH-1:0] fwd_data_q, fwd_data_d;

    assign accept = bus.i_start & ~bus.i_rd_en & ~i_rst;

    for (genvar k = 0; k < N_GF; k++) begin : g_lane
        localparam int LSB = lane_lsb(WIDTH, k);
        gf_mul u_mul (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_start (accept),
            .in_1    (bus.i_a[LSB +: GF_W]),
            .in_2    (bus.i_b),
            .out     (prod[LSB +: GF_W]),
            .done    (done[k])
        );
    end

    assign valid   = &done;
    assign wren    = valid & ~i_rst;
    assign old_val = fwd_hit_q ? fwd_data_q : q1;
    assign wdata   = prod ^ old_val;
    assign rd_addr = bus.i_rd_en ? bus.i_rd_addr : bus.i_addr;

    // The RAM read issued this cycle misses the write committing now.
    always_comb begin
        addr_d     = accept ? bus.i_addr : addr_q;
        fwd_hit_d  = accept & wren & (bus.i_addr == addr_q);
        fwd_data_d = wdata;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_q     <= '0;
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            addr_q     <= addr_d;
            fwd_hit_q  <= fwd_hit_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    mem_dual #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .i_clk   (i_clk),
        .data0_i (wdata),
        .addr0_i (addr_q),
        .wren0_i (wren),
        .q0_o    (q0),
        .data1_i ('0),
        .addr1_i (rd_addr),
        .wren1_i (1'b0),
        .q1_o    (q1)
    );

    logic unused_q0;
    assign unused_q0 = ^q0;

    assign bus.o_prod    = prod;
    assign bus.o_valid   = valid & ~i_rst;
    assign bus.o_rd_data = q1;

endmodule

// File: tb/tb_gf_mul_mem_dual.sv
// Bench for gf_mul_mem_dual: vector table, directed corner cases,
// random ops against a memory model, then a full readout.
module tb_gf_mul_mem_dual;

    localparam int N  = 8;
    localparam int D  = 16;
    localparam int W  = N * 8;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gf_mul_mem_dual_if #(.N_GF(N), .DEPTH(D)) bus ();

    gf_mul_mem_dual #(.N_GF(N), .DEPTH(D)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
    } vec_t;

    vec_t       vec [6];
    logic [W-1:0] mem_m [D];
    logic [W-1:0] pq [$];
    logic [W-1:0] rq [$];
    int         n_chk  = 0;
    int         n_pass = 0;
    logic       exp_v   = 1'b0;
    logic       rd_pend = 1'b0;

    function automatic logic [7:0] gm(input logic [7:0] a,
                                      input logic [7:0] b);
        logic [7:0] r, x, y;
        r = '0; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) r = r ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return r;
    endfunction

    function automatic logic [W-1:0] vmul(input logic [W-1:0] a,
                                          input logic [7:0] b);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++)
            r[W-8-8*k +: 8] = gm(a[W-8-8*k +: 8], b);
        return r;
    endfunction

    function automatic logic [W-1:0] rep(input logic [7:0] x);
        return {N{x}};
    endfunction

    task automatic check(input string nm, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        check("o_valid", 64'(bus.o_valid), 64'(exp_v & ~rst));
        if (exp_v && !rst && pq.size() > 0)
            check("o_prod", bus.o_prod, pq.pop_front());
        if (rd_pend && rq.size() > 0)
            check("o_rd_data", bus.o_rd_data, rq.pop_front());
        exp_v   <= bus.i_start & ~bus.i_rd_en & ~rst;
        rd_pend <= bus.i_rd_en;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op_exp(input logic [W-1:0] a, input logic [7:0] b,
                          input logic [AW-1:0] addr, input logic [W-1:0] p);
        bus.i_start = 1'b1;
        bus.i_rd_en = 1'b0;
        bus.i_a     = a;
        bus.i_b     = b;
        bus.i_addr  = addr;
        pq.push_back(p);
        mem_m[addr] = mem_m[addr] ^ p;
        tick();
        bus.i_start = 1'b0;
    endtask

    task automatic op(input logic [W-1:0] a, input logic [7:0] b,
                      input logic [AW-1:0] addr);
        op_exp(a, b, addr, vmul(a, b));
    endtask

    task automatic rd(input logic [AW-1:0] addr, input logic [W-1:0] exp);
        bus.i_rd_en   = 1'b1;
        bus.i_rd_addr = addr;
        rq.push_back(exp);
        tick();
        bus.i_rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    logic [W-1:0] t_a, t_p;

    initial begin
        vec[0] = '{8'h57, 8'h83, 8'hC1};
        vec[1] = '{8'h80, 8'h02, 8'h1B};
        vec[2] = '{8'h3C, 8'h01, 8'h3C};
        vec[3] = '{8'h00, 8'hFF, 8'h00};
        vec[4] = '{8'h57, 8'h13, 8'hFE};
        vec[5] = '{8'h02, 8'h87, 8'h15};
        for (int i = 0; i < D; i++) mem_m[i] = '0;

        bus.i_start = 0; bus.i_a = '0; bus.i_b = '0;
        bus.i_addr = '0; bus.i_rd_en = 0; bus.i_rd_addr = '0;
        repeat (3) tick();
        check("rst_valid", 64'(bus.o_valid), '0);
        check("rst_prod", bus.o_prod, '0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++)
            op_exp(rep(vec[i].a), vec[i].b, AW'(8 + i), rep(vec[i].p));

        t_a = '0; t_a[W-1 -: 8] = 8'h57;
        t_p = '0; t_p[W-1 -: 8] = 8'hC1;
        op_exp(t_a, 8'h83, 4'd14, t_p);
        op_exp(64'h0102040810204080, 8'h02, 4'd15, 64'h020408102040801B);
        idle(2);

        op(rep(8'h01), 8'h05, 4'd3);
        op(rep(8'h01), 8'h07, 4'd3);
        idle(2);
        rd(4'd3, rep(8'h02));

        bus.i_start = 1; bus.i_rd_en = 1;
        bus.i_addr = 4'd5; bus.i_rd_addr = 4'd5;
        bus.i_a = rep(8'hFF); bus.i_b = 8'hFF;
        rq.push_back('0);
        tick();
        bus.i_start = 0; bus.i_rd_en = 0;
        idle(2);
        rd(4'd5, '0);

        op(rep(8'h11), 8'h01, 4'd7);
        rd(4'd7, '0);
        rd(4'd7, rep(8'h11));
        idle(2);

        bus.i_start = 1; bus.i_addr = 4'd2;
        bus.i_a = rep(8'h33); bus.i_b = 8'h03;
        tick();
        bus.i_start = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(1);
        rd(4'd2, '0);
        idle(2);

        repeat (1000) op({$urandom, $urandom}, 8'($urandom), AW'($urandom));
        idle(2);
        for (int i = 0; i < D; i++) rd(AW'(i), mem_m[i]);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
